// File: rtl/hex_display_pkg.sv
// Glyph codes, seven-segment patterns and the glyph decode shared by the display controller.
package hex_display_pkg;

    localparam logic [4:0] GLYPH_MINUS = 5'h10;
    localparam logic [4:0] GLYPH_R     = 5'h11;
    localparam logic [4:0] GLYPH_E     = 5'h12;
    localparam logic [4:0] GLYPH_N     = 5'h13;
    localparam logic [4:0] GLYPH_BLANK = 5'h1F;

    // Patterns are active-high {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_N     = 7'h54;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] glyph_to_seg(input logic [4:0] code);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (!code[4]) begin
            seg = SEG_HEX[code[3:0]];
        end else begin
            case (code)
                GLYPH_MINUS: seg = SEG_MINUS;
                GLYPH_R:     seg = SEG_R;
                GLYPH_E:     seg = SEG_E;
                GLYPH_N:     seg = SEG_N;
                default:     seg = SEG_BLANK;
            endcase
        end
        return seg;
    endfunction

endpackage

// File: rtl/hex_glyph_dec.sv
// One digit: glyph code plus dp plus blank to active-high segments {dp,g,f,e,d,c,b,a}.
module hex_glyph_dec (
    input  logic [4:0] code,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);
    import hex_display_pkg::*;

    always_comb begin
        seg = {dp, glyph_to_seg(code)};
        if (blank) begin
            seg = 8'h00;
        end
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller with static and scanned outputs, blink and blanking.
// Leading-zero blanking is built only when HEX_DISPLAY_LZB_EN is defined.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 12500000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [5*NUM_DIGITS-1:0] digit_codes,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [8*NUM_DIGITS-1:0] seg_static,
    output logic [7:0]              seg_mux,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_tick
);
    import hex_display_pkg::*;

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [7:0] SEG_INACT = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_INACT = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [5*NUM_DIGITS-1:0] sh_codes;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [NUM_DIGITS-1:0]   sh_blink;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_codes <= {NUM_DIGITS{GLYPH_BLANK}};
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_blink <= '0;
        end else if (load) begin
            sh_codes <= digit_codes;
            sh_dp    <= dp_mask;
            sh_blank <= blank_mask;
            sh_blink <= blink_mask;
        end
    end

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               blink_tc;

    assign blink_tc = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            blink_cnt <= blink_tc ? '0 : blink_cnt + 1'b1;
            if (blink_tc) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  idx_next;
    logic              scan_tc;

    assign scan_tc = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        idx_next = scan_idx;
        if (scan_tc) begin
            idx_next = (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    logic [NUM_DIGITS-1:0] eff_blank;
    logic [NUM_DIGITS-1:0] lzb_sup;

    assign eff_blank = sh_blank | (sh_blink & {NUM_DIGITS{blink_phase}});

`ifdef HEX_DISPLAY_LZB_EN
    // Suppression runs from the top digit down and stops at the first significant digit; digit 0 always shows.
    always_comb begin : lzb_scan
        logic lead;
        lead    = 1'b1;
        lzb_sup = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead       = lead & ((sh_codes[5*i +: 5] == 5'h00) | eff_blank[i]);
            lzb_sup[i] = lead;
        end
    end
`else
    assign lzb_sup = '0;
`endif

    logic [7:0] seg_raw [NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        hex_glyph_dec u_dec (
            .code  (lzb_sup[g] ? GLYPH_BLANK : sh_codes[5*g +: 5]),
            .dp    (sh_dp[g]),
            .blank (eff_blank[g]),
            .seg   (seg_raw[g])
        );
    end

    // seg_mux is loaded from the same source as seg_static so the two never disagree for the scanned digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt   <= '0;
            scan_idx   <= '0;
            seg_static <= {NUM_DIGITS{SEG_INACT}};
            seg_mux    <= SEG_INACT;
            dig_sel    <= DIG_INACT;
            frame_tick <= 1'b0;
        end else begin
            scan_cnt <= scan_tc ? '0 : scan_cnt + 1'b1;
            scan_idx <= idx_next;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                seg_static[8*i +: 8] <= seg_raw[i] ^ SEG_INACT;
            end
            seg_mux    <= seg_raw[idx_next] ^ SEG_INACT;
            dig_sel    <= scan_tc ? DIG_INACT : ((NUM_DIGITS'(1) << idx_next) ^ DIG_INACT);
            frame_tick <= scan_tc && (idx_next == '0);
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with 4 digits, fast scan and blink, active-low outputs.
module tb_hex_display_ctrl;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            load = 1'b0;
    logic [5*N-1:0]  digit_codes = '0;
    logic [N-1:0]    dp_mask = '0;
    logic [N-1:0]    blank_mask = '0;
    logic [N-1:0]    blink_mask = '0;
    logic [8*N-1:0]  seg_static;
    logic [7:0]      seg_mux;
    logic [N-1:0]    dig_sel;
    logic            frame_tick;

    int vectors = 0;
    int miscompares = 0;
    int k = 0;

    hex_display_ctrl #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (4),
        .BLINK_DIV  (8),
        .ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .digit_codes (digit_codes),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .seg_static  (seg_static),
        .seg_mux     (seg_mux),
        .dig_sel     (dig_sel),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // k counts falling edges since the last reset release, i.e. rising edges already taken.
    task automatic to(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic apply(input logic [4:0] c3, input logic [4:0] c2, input logic [4:0] c1,
                         input logic [4:0] c0, input logic [3:0] dp, input logic [3:0] bl,
                         input logic [3:0] bk);
        digit_codes = {c3, c2, c1, c0};
        dp_mask     = dp;
        blank_mask  = bl;
        blink_mask  = bk;
        load        = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_seg_static", seg_static, 32'hFFFF_FFFF);
        chk("rst_seg_mux", {24'h0, seg_mux}, 32'hFF);
        chk("rst_dig_sel", {28'h0, dig_sel}, 32'hF);
        chk("rst_frame_tick", {31'h0, frame_tick}, 32'h0);

        rst_n = 1'b1;
        k = 0;
        apply(5'h3, 5'h2, 5'h1, 5'h0, 4'b0001, 4'b0000, 4'b0000);
        to(1);
        load = 1'b0;
        chk("latency_not_yet", seg_static, 32'hFFFF_FFFF);
        chk("scan0_dig_sel", {28'h0, dig_sel}, 32'hE);
        to(2);
        chk("load_seg_static", seg_static, 32'hB0A4_F940);
        chk("scan0_seg_mux", {24'h0, seg_mux}, 32'h40);
        to(4);
        chk("dead0_dig_sel", {28'h0, dig_sel}, 32'hF);
        chk("dead0_seg_mux", {24'h0, seg_mux}, 32'hF9);
        to(5);
        chk("scan1_dig_sel", {28'h0, dig_sel}, 32'hD);
        to(9);
        chk("scan2_dig_sel", {28'h0, dig_sel}, 32'hB);
        chk("scan2_seg_mux", {24'h0, seg_mux}, 32'hA4);

        #2 rst_n = 1'b0;
        #1;
        chk("async_seg_static", seg_static, 32'hFFFF_FFFF);
        chk("async_seg_mux", {24'h0, seg_mux}, 32'hFF);
        chk("async_dig_sel", {28'h0, dig_sel}, 32'hF);
        chk("async_frame_tick", {31'h0, frame_tick}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        apply(5'h3, 5'h2, 5'h1, 5'h0, 4'b0001, 4'b0000, 4'b0000);
        to(1);
        load = 1'b0;
        chk("restart_dig_sel", {28'h0, dig_sel}, 32'hE);
        chk("restart_seg_mux", {24'h0, seg_mux}, 32'hFF);
        to(12);
        chk("dead2_dig_sel", {28'h0, dig_sel}, 32'hF);
        to(13);
        chk("scan3_dig_sel", {28'h0, dig_sel}, 32'h7);
        chk("scan3_seg_mux", {24'h0, seg_mux}, 32'hB0);
        to(15);
        chk("pre_wrap_tick", {31'h0, frame_tick}, 32'h0);
        to(16);
        chk("wrap_tick", {31'h0, frame_tick}, 32'h1);
        chk("wrap_dig_sel", {28'h0, dig_sel}, 32'hF);
        chk("wrap_seg_mux", {24'h0, seg_mux}, 32'h40);
        to(17);
        chk("post_wrap_tick", {31'h0, frame_tick}, 32'h0);
        chk("post_wrap_dig_sel", {28'h0, dig_sel}, 32'hE);

        apply(5'h3, 5'h2, 5'h1, 5'h0, 4'b0001, 4'b1000, 4'b0100);
        to(18);
        load = 1'b0;
        to(19);
        chk("blink_on_a", seg_static, 32'hFFA4_F940);
        to(24);
        chk("blink_on_b", seg_static, 32'hFFA4_F940);
        to(25);
        chk("blink_off_a", seg_static, 32'hFFFF_F940);
        to(32);
        chk("blink_off_b", seg_static, 32'hFFFF_F940);
        to(33);
        chk("blink_on_c", seg_static, 32'hFFA4_F940);

        to(36);
        chk("dead_load_dig_sel", {28'h0, dig_sel}, 32'hF);
        chk("dead_load_seg_mux", {24'h0, seg_mux}, 32'hF9);
        apply(5'h13, 5'h12, 5'h14, 5'h11, 4'b0000, 4'b0000, 4'b0000);
        to(37);
        load = 1'b0;
        chk("enable_old_seg_mux", {24'h0, seg_mux}, 32'hF9);
        chk("enable_dig_sel", {28'h0, dig_sel}, 32'hD);
        to(38);
        chk("glyph_seg_static", seg_static, 32'hAB86_FFAF);
        chk("blank_seg_mux", {24'h0, seg_mux}, 32'hFF);
        to(40);
        chk("e_dead_seg_mux", {24'h0, seg_mux}, 32'h86);
        to(41);
        chk("e_dig_sel", {28'h0, dig_sel}, 32'hB);
        to(45);
        chk("n_seg_mux", {24'h0, seg_mux}, 32'hAB);
        to(48);
        chk("frame2_tick", {31'h0, frame_tick}, 32'h1);
        chk("r_seg_mux", {24'h0, seg_mux}, 32'hAF);

        apply(5'h0, 5'h0, 5'h5, 5'h0, 4'b0000, 4'b0000, 4'b0000);
        to(49);
        load = 1'b0;
        to(50);
`ifdef HEX_DISPLAY_LZB_EN
        chk("lzb_50", seg_static, 32'hFFFF_92C0);
`else
        chk("zeros_50", seg_static, 32'hC0C0_92C0);
`endif
        apply(5'h0, 5'h0, 5'h0, 5'h0, 4'b0100, 4'b0000, 4'b0000);
        to(51);
        load = 1'b0;
        to(52);
`ifdef HEX_DISPLAY_LZB_EN
        chk("lzb_all_zero_dp", seg_static, 32'hFF7F_FFC0);
`else
        chk("all_zero_dp", seg_static, 32'hC040_C0C0);
`endif
        apply(5'h8, 5'h0, 5'h1, 5'h0, 4'b0000, 4'b1000, 4'b0000);
        to(53);
        load = 1'b0;
        to(54);
`ifdef HEX_DISPLAY_LZB_EN
        chk("lzb_through_blank", seg_static, 32'hFFFF_F9C0);
`else
        chk("blank_then_zero", seg_static, 32'hFFC0_F9C0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Parametrised multi-digit seven-segment display controller for the calculator front panel. It generalises the single-digit hex decoder to NUM_DIGITS digits. It adds a load-captured display buffer, an extended glyph set, per-digit blank, blink and decimal-point control, and both static (one bus per digit) and time-multiplexed (shared segments plus scanned digit select) outputs. It sits between the calculator result/format logic and the board HEX pins.

Parameters:
NUM_DIGITS, 6, number of digits (1..8)
SCAN_DIV, 50000, clock cycles each digit is driven in multiplexed mode (>=2)
BLINK_DIV, 12500000, clock cycles per blink half-period (>=2)
ACTIVE_LOW, 1, 1 = segment and digit-select outputs are active-low; 0 = active-high

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  capture strobe for all data/mask inputs
digit_codes  in  5*NUM_DIGITS  5-bit glyph code per digit; digit 0 in the LSBs and rightmost
dp_mask  in  NUM_DIGITS  decimal point on per digit
blank_mask  in  NUM_DIGITS  force digit blank
blink_mask  in  NUM_DIGITS  digit blinks
seg_static  out  8*NUM_DIGITS  per-digit segments {dp,g,f,e,d,c,b,a}
seg_mux  out  8  shared segments for the scanned digit
dig_sel  out  NUM_DIGITS  one-hot digit enable for multiplexed mode
frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Glyph map: 0x00-0x0F hex 0-F; 0x10 minus (g only); 0x11 'r' (e,g); 0x12 'E'; 0x13 'n' (c,e,g); 0x14-0x1F blank.
- Reset (async assert, sync release):
  - shadow codes = 0x1F and all masks 0;
  - scan index 0, prescaler 0, blink phase 0;
  - seg_static, seg_mux and dig_sel all inactive (all 1s if ACTIVE_LOW, else 0s);
  - frame_tick 0.
- load=1 on an edge: all inputs are registered into the shadow. load held high recaptures every cycle. No handshake is required; load is accepted in any state.
- Latency: load at edge N, shadow valid after N, seg_static reflects it after edge N+1 (2 cycles total).
- Effective blank per digit = blank_mask | (blink_mask & blink_phase). A blanked digit drives all segments off, including dp.
- Blink: counter 0..BLINK_DIV-1. blink_phase toggles on the terminal count.
- Scan: prescaler 0..SCAN_DIV-1.
  - On the terminal count, index advances (NUM_DIGITS-1 wraps to 0).
  - dig_sel is inactive for exactly one cycle at each index change (anti-ghost dead time).
  - seg_mux updates in that same cycle.
  - frame_tick pulses in the cycle index becomes 0.
- seg_mux always equals the seg_static slice of the current index, except during dead time, when dig_sel is inactive.
- All outputs are registered; there are no combinational input-to-output paths.
- ACTIVE_LOW inverts seg_static, seg_mux and dig_sel only.

Optional Feature:
HEX_DISPLAY_LZB_EN.
- Defined: leading-zero blanking. Starting from digit NUM_DIGITS-1 and moving down, digits with code 0x00, or with effective blank set, are blanked until the first digit with any other code. Digit 0 is never suppressed. A dp on a suppressed digit is still shown.
- Undefined: every digit displays its code; the logic is absent.

Decomposition:
- Package hex_display_pkg: 5-bit glyph code constants (GLYPH_MINUS, GLYPH_R, GLYPH_E, GLYPH_N, GLYPH_BLANK), the 7-bit segment pattern constants, and the glyph-to-segment decode function.
- Sub-module hex_glyph_dec: combinational 5-bit code plus dp plus blank to 8-bit active-high segments. It is instantiated NUM_DIGITS times, and polarity is applied at the top.

Test Plan:
Bench uses NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=8, ACTIVE_LOW=1.
1. Reset mid-scan (rst_n low at index 2) -> all outputs 0xFF/0xF immediately, asynchronously; after release, index restarts at 0.
2. Load codes {0x3,0x2,0x1,0x0} (digits 3..0), dp_mask=0001 -> two cycles later: digit0 seg_static = ~0x3F & 0x7F (dp on, active-low), digit1 = 0xF9.
3. Scan -> dig_sel sequence 1110, 1101, 1011, 0111 (active-low). Each is held 3 cycles, plus 1 dead cycle of 1111 between them. frame_tick pulses once every 16 cycles.
4. blink_mask=0100 -> digit2 alternates between glyph and 0xFF every 8 cycles. blank_mask=1000 keeps digit3 at 0xFF regardless.
5. Load 0x11 and 0x14 -> 'r' pattern 0xAF and blank 0xFF. Load during dead time -> no glitch, and the new value appears on the next enable.
6. With HEX_DISPLAY_LZB_EN, codes {0x0,0x0,0x5,0x0} -> digits 3 and 2 blank, "50" shown. Codes {0,0,0,0} -> only digit 0 shows "0".
